// File: rtl/bht_controller_if.sv
// Fetch/commit-side bundle for the shared branch history table controller.
// The master drives lookup and update requests; the slave is the controller.
interface bht_controller_if #(
  parameter int PC_WIDTH = 32,
  parameter int UQ_DEPTH = 4
);
  localparam int CW = $clog2(UQ_DEPTH + 1);

  logic                lookup_valid;
  logic [PC_WIDTH-1:0] lookup_pc;
  logic                lookup_ready;
  logic                pred_valid;
  logic                pred_taken;
  logic                upd_valid;
  logic [PC_WIDTH-1:0] upd_pc;
  logic                upd_taken;
  logic                upd_ready;
  logic [CW-1:0]       upd_count;
  logic                busy;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken,
    input  lookup_ready, pred_valid, pred_taken, upd_ready, upd_count, busy
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken,
    output lookup_ready, pred_valid, pred_taken, upd_ready, upd_count, busy
  );
endinterface

// File: rtl/bht_controller.sv
// Shared 2-bit saturating branch counter table with a single access slot per cycle,
// arbitrated between fetch lookups and a FIFO of resolved commit updates.
module bht_controller #(
  parameter int         INDEX_BITS = 6,
  parameter int         PC_WIDTH   = 32,
  parameter int         UQ_DEPTH   = 4,
  parameter logic [1:0] INIT_CTR   = 2'b01
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  bht_controller_if.slave bus
);
  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int CW      = $clog2(UQ_DEPTH + 1);
  localparam int PW      = $clog2(UQ_DEPTH);

  localparam logic [CW-1:0]         FULL     = CW'(UQ_DEPTH);
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);
  localparam logic [PW-1:0]         LAST_PTR = PW'(UQ_DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] uq_idx_q [UQ_DEPTH];
  logic [UQ_DEPTH-1:0]   uq_taken_q;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;

  logic                  busy, lookup_ready, upd_ready;
  logic                  lookup_acc, upd_acc, drain, tbl_we;
  logic [INDEX_BITS-1:0] lookup_idx, upd_idx, head_idx, wr_idx;
  logic                  head_taken;
  logic [1:0]            head_ctr, wr_ctr;
  logic                  unused_pc_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // Untagged table: both ports index with the word-aligned low PC bits.
  assign lookup_idx     = bus.lookup_pc[INDEX_BITS+1:2];
  assign upd_idx        = bus.upd_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{bus.lookup_pc[PC_WIDTH-1:INDEX_BITS+2], bus.lookup_pc[1:0],
                            bus.upd_pc[PC_WIDTH-1:INDEX_BITS+2], bus.upd_pc[1:0]};

  assign head_idx   = uq_idx_q[rd_ptr_q];
  assign head_taken = uq_taken_q[rd_ptr_q];
  assign head_ctr   = table_q[head_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + INDEX_BITS'(1);
        if (init_idx_q == LAST_IDX) state_d = RUN;
      end
      RUN: state_d = RUN;
    endcase
  end

  // A full queue withholds lookup_ready, so the drain always gets the slot.
  always_comb begin
    busy         = (state_q == INIT);
    upd_ready    = !busy && (count_q < FULL);
    lookup_ready = !busy && (count_q != FULL);
    lookup_acc   = bus.lookup_valid && lookup_ready;
    upd_acc      = bus.upd_valid && upd_ready;
    drain        = !busy && !lookup_acc && (count_q != '0);
    tbl_we       = busy || drain;
    wr_idx       = busy ? init_idx_q : head_idx;
    wr_ctr       = busy ? INIT_CTR : sat_update(head_ctr, head_taken);
  end

  always_comb begin
    pred_valid_d = lookup_acc;
    pred_taken_d = lookup_acc ? table_q[lookup_idx][1] : pred_taken_q;
    rd_ptr_d     = drain   ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d     = upd_acc ? next_ptr(wr_ptr_q) : wr_ptr_q;
    case ({upd_acc, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Table and queue payload carry no reset; the sweep and the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (tbl_we) table_q[wr_idx] <= wr_ctr;
    if (upd_acc) begin
      uq_idx_q[wr_ptr_q]   <= upd_idx;
      uq_taken_q[wr_ptr_q] <= bus.upd_taken;
    end
  end

  assign bus.busy         = busy;
  assign bus.lookup_ready = lookup_ready;
  assign bus.upd_ready    = upd_ready;
  assign bus.upd_count    = count_q;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_taken_q;
endmodule
